// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : pong_ball_engine
// Brief    : Ball physics and rally controller for one side of the pong game.
//            Optional BALL_SPIN_EN adds a signed hit_offset spin input.
// Revision : 1.0 - initial release
// ============================================================================
module pong_ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_MARGIN = 20,
  parameter int X_STEP      = 10,
  parameter int GRAV_PERIOD = 4,
  parameter int BASE_PERIOD = 270000,
  parameter int PERIOD_W    = 20,
  parameter int MAX_SCORE   = 15
) (
  input  logic              clk_25MHZ,
  input  logic              reset,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [9:0]        rx_y,
  input  logic signed [7:0] rx_vy,
  input  logic [2:0]        rx_grav_phase,
  input  logic              rx_fast,
  input  logic              hit,
  input  logic [9:0]        hit_speed,
`ifdef BALL_SPIN_EN
  input  logic signed [3:0] hit_offset,
`endif
  input  logic              restart,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [9:0]        tx_y,
  output logic signed [7:0] tx_vy,
  output logic [2:0]        tx_grav_phase,
  output logic              tx_fast,
  output logic [9:0]        ball_x,
  output logic [9:0]        ball_y,
  output logic signed [7:0] ball_vy,
  output logic              moving_right,
  output logic [7:0]        score,
  output logic              game_over,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INBOUND  = 3'd1,
    S_OUTBOUND = 3'd2,
    S_HANDOFF  = 3'd3,
    S_MISS     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  localparam logic [9:0]          c_margin    = 10'(BALL_MARGIN);
  localparam logic [9:0]          c_x_step    = 10'(X_STEP);
  localparam logic [9:0]          c_x_turn    = 10'(2 * X_STEP);
  localparam logic [9:0]          c_miss_x    = 10'(H_RES - BALL_MARGIN);
  localparam logic [9:0]          c_y_bottom  = 10'(V_RES - 1);
  localparam logic signed [10:0]  c_y_max     = 11'(V_RES - 1);
  localparam logic [2:0]          c_grav_last = 3'(GRAV_PERIOD - 1);
  localparam logic [3:0]          c_grav_mod  = 4'(GRAV_PERIOD);
  localparam logic [PERIOD_W-1:0] c_base      = PERIOD_W'(BASE_PERIOD);
  localparam logic [7:0]          c_max_score = 8'(MAX_SCORE);

  state_t              r_state;
  logic [9:0]          r_ball_x;
  logic [9:0]          r_ball_y;
  logic signed [7:0]   r_ball_vy;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_tick;
  logic [2:0]          r_grav;
  logic [7:0]          r_score;
  logic                r_game_over;
  logic                r_tx_fast;
  logic [2:0]          r_tx_grav_phase;

  logic                w_step_due;
  logic signed [10:0]  w_y_sum;
  logic signed [7:0]   w_vy_grav;
  logic [9:0]          w_y_next;
  logic signed [7:0]   w_vy_next;
  logic [2:0]          w_grav_next;
  logic [2:0]          w_grav_load;
  logic [PERIOD_W-1:0] w_hit_period;
  logic signed [7:0]   w_vy_hit;

  assign w_step_due  = (r_tick >= r_period);
  assign w_grav_load = 3'(({1'b0, rx_grav_phase}) % c_grav_mod);

  // Vertical update: gravity first, then wall clamp negates the result.
  always_comb begin
    w_y_sum     = {1'b0, r_ball_y} + {{3{r_ball_vy[7]}}, r_ball_vy};
    w_vy_grav   = r_ball_vy;
    w_grav_next = r_grav + 3'd1;
    if (r_grav == c_grav_last) begin
      w_grav_next = 3'd0;
      if (r_ball_vy != 8'sd127)
        w_vy_grav = r_ball_vy + 8'sd1;
    end
    w_y_next  = w_y_sum[9:0];
    w_vy_next = w_vy_grav;
    if (w_y_sum >= c_y_max || w_y_sum <= 11'sd0) begin
      w_y_next  = (w_y_sum >= c_y_max) ? c_y_bottom : 10'd0;
      w_vy_next = (w_vy_grav == -8'sd128) ? 8'sd127 : -w_vy_grav;
    end
  end

  // Speed tier from paddle speed, pure shifts of the base period.
  always_comb begin
    w_hit_period = c_base;
    if (hit_speed >= 10'd8)
      w_hit_period = c_base >> 3;
    else if (hit_speed >= 10'd4)
      w_hit_period = c_base >> 2;
    else if (hit_speed >= 10'd2)
      w_hit_period = c_base >> 1;
  end

`ifdef BALL_SPIN_EN
  logic signed [8:0] w_vy_spin;
  always_comb begin
    w_vy_spin = {r_ball_vy[7], r_ball_vy} + {{5{hit_offset[3]}}, hit_offset};
    if (w_vy_spin > 9'sd127)
      w_vy_hit = 8'sd127;
    else if (w_vy_spin < -9'sd127)
      w_vy_hit = -8'sd127;
    else
      w_vy_hit = w_vy_spin[7:0];
  end
`else
  assign w_vy_hit = r_ball_vy;
`endif

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_ball_x        <= c_margin;
      r_ball_y        <= 10'd80;
      r_ball_vy       <= -8'sd3;
      r_period        <= c_base;
      r_tick          <= '0;
      r_grav          <= 3'd0;
      r_score         <= 8'd0;
      r_game_over     <= 1'b0;
      r_tx_fast       <= 1'b0;
      r_tx_grav_phase <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_ball_x  <= c_margin;
            r_ball_y  <= rx_y;
            r_ball_vy <= rx_vy;
            r_grav    <= w_grav_load;
            r_period  <= rx_fast ? (c_base >> 1) : c_base;
            r_tick    <= '0;
            r_state   <= S_INBOUND;
          end
        end
        S_INBOUND: begin
          if (hit) begin
            r_period  <= w_hit_period;
            r_tick    <= '0;
            r_ball_vy <= w_vy_hit;
            r_state   <= S_OUTBOUND;
          end else if (r_ball_x >= c_miss_x) begin
            r_game_over <= 1'b1;
            r_state     <= S_MISS;
          end else if (w_step_due) begin
            r_tick    <= '0;
            r_ball_x  <= r_ball_x + c_x_step;
            r_ball_y  <= w_y_next;
            r_ball_vy <= w_vy_next;
            r_grav    <= w_grav_next;
          end else begin
            r_tick <= r_tick + PERIOD_W'(1);
          end
        end
        S_OUTBOUND: begin
          if (w_step_due) begin
            r_tick    <= '0;
            r_ball_y  <= w_y_next;
            r_ball_vy <= w_vy_next;
            r_grav    <= w_grav_next;
            // Landing short of a full step means the ball has left our half.
            if (r_ball_x < c_x_turn) begin
              r_ball_x        <= 10'd0;
              r_score         <= r_score + 8'd1;
              r_tx_fast       <= (r_period < c_base);
              r_tx_grav_phase <= w_grav_next;
              r_state         <= S_HANDOFF;
            end else begin
              r_ball_x <= r_ball_x - c_x_step;
            end
          end else begin
            r_tick <= r_tick + PERIOD_W'(1);
          end
        end
        S_HANDOFF: begin
          if (tx_ready) begin
            if (r_score == c_max_score) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_period <= c_base;
              r_state  <= S_IDLE;
            end
          end
        end
        S_MISS, S_OVER: begin
          if (restart) begin
            r_score     <= 8'd0;
            r_game_over <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready      = (r_state == S_IDLE);
  assign tx_valid      = (r_state == S_HANDOFF);
  assign moving_right  = (r_state == S_INBOUND);
  assign state_o       = r_state;
  assign ball_x        = r_ball_x;
  assign ball_y        = r_ball_y;
  assign ball_vy       = r_ball_vy;
  assign tx_y          = r_ball_y;
  assign tx_vy         = r_ball_vy;
  assign tx_grav_phase = r_tx_grav_phase;
  assign tx_fast       = r_tx_fast;
  assign score         = r_score;
  assign game_over     = r_game_over;

endmodule
`default_nettype wire
